// File: rtl/basic_system_ocram_pkg.sv
// =====================================================================
// basic_system_ocram_pkg: shared widths and types for the OCRAM arbiter
// Revision: 1.0
// =====================================================================
`timescale 1ns/1ps
`default_nettype none

package basic_system_ocram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 4;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

`default_nettype wire

// File: rtl/basic_system_ocram_rr_pick.sv
// =====================================================================
// basic_system_ocram_rr_pick: weighted round-robin grant for two ports
// Revision: 1.0
// =====================================================================
`timescale 1ns/1ps
`default_nettype none

module basic_system_ocram_rr_pick
  import basic_system_ocram_pkg::*;
#(
  parameter int QUANTUM = 4
) (
  input  logic [1:0]       req_i,
  input  port_e            last_owner_i,
  input  logic [CNT_W-1:0] grant_cnt_i,
  output logic [1:0]       grant_o
);

  localparam logic [CNT_W-1:0] QUANTUM_C = CNT_W'(QUANTUM);

  logic keep;
  logic [1:0] owner_oh;

  // A zero count means nobody currently owns the RAM, so the port after last_owner wins.
  assign keep     = (grant_cnt_i != '0) && (grant_cnt_i < QUANTUM_C);
  assign owner_oh = (last_owner_i == PORT1) ? 2'b10 : 2'b01;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = keep ? owner_oh : ~owner_oh;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/basic_system_ocram_arbiter.sv
// =====================================================================
// basic_system_ocram_arbiter: two-master Avalon-MM front end for OCRAM
// Revision: 1.0
// =====================================================================
`timescale 1ns/1ps
`default_nettype none

module basic_system_ocram_arbiter
  import basic_system_ocram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int QUANTUM = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_writedata,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam logic [CNT_W-1:0] QUANTUM_C = CNT_W'(QUANTUM);

  port_e            last_owner_q, last_owner_d;
  logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  port_e            rd_port_q, rd_port_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       granted;
  port_e      winner;
  logic       sel_read;
  logic       sel_write;
  logic       rd_fire;

  // Requests are masked in reset so both ports stall and the RAM stays deselected.
  assign req = {s1_read | s1_write, s0_read | s0_write} & {2{reset_n}};

  basic_system_ocram_rr_pick #(
    .QUANTUM (QUANTUM)
  ) u_rr_pick (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .grant_cnt_i  (grant_cnt_q),
    .grant_o      (grant)
  );

  assign granted   = |grant;
  assign winner    = grant[1] ? PORT1 : PORT0;
  assign sel_read  = grant[1] ? s1_read  : s0_read;
  assign sel_write = grant[1] ? s1_write : s0_write;
  assign rd_fire   = granted & sel_read & ~sel_write;

  assign ram_address    = grant[1] ? s1_address    : s0_address;
  assign ram_byteenable = grant[1] ? s1_byteenable : s0_byteenable;
  assign ram_writedata  = grant[1] ? s1_writedata  : s0_writedata;
  assign ram_chipselect = granted;
  assign ram_write      = granted & sel_write;
  assign ram_clken      = reset_n;

  assign s0_waitrequest   = ~grant[0];
  assign s1_waitrequest   = ~grant[1];
  assign s0_readdata      = ram_readdata;
  assign s1_readdata      = ram_readdata;
  assign s0_readdatavalid = rd_pend_q & (rd_port_q == PORT0);
  assign s1_readdatavalid = rd_pend_q & (rd_port_q == PORT1);

  always_comb begin
    last_owner_d = last_owner_q;
    grant_cnt_d  = grant_cnt_q;
    rd_pend_d    = rd_fire;
    rd_port_d    = rd_port_q;
    if (granted) begin
      if (winner == last_owner_q) begin
        grant_cnt_d = (grant_cnt_q >= QUANTUM_C) ? QUANTUM_C : grant_cnt_q + 1'b1;
      end else begin
        last_owner_d = winner;
        grant_cnt_d  = CNT_W'(1);
      end
    end else begin
      grant_cnt_d = '0;
    end
    if (rd_fire) begin
      rd_port_d = winner;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner_q <= PORT1;
      grant_cnt_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_port_q    <= PORT0;
    end else begin
      last_owner_q <= last_owner_d;
      grant_cnt_q  <= grant_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_port_q    <= rd_port_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_basic_system_ocram_arbiter.sv
// =====================================================================
// tb_basic_system_ocram_arbiter: directed self-checking bench with RAM model
// Revision: 1.0
// =====================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_basic_system_ocram_arbiter;

  logic        clk;
  logic        reset_n;
  logic [12:0] s0_address, s1_address;
  logic [1:0]  s0_byteenable, s1_byteenable;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [15:0] s0_writedata, s1_writedata;
  logic        s0_waitrequest, s1_waitrequest;
  logic [15:0] s0_readdata, s1_readdata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic [12:0] ram_address;
  logic [1:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [15:0] ram_writedata;
  logic [15:0] ram_readdata;

  int n_tests = 0;
  int n_fail  = 0;

  basic_system_ocram_arbiter #(
    .ADDR_W  (13),
    .DATA_W  (16),
    .QUANTUM (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s0_address       (s0_address),
    .s0_byteenable    (s0_byteenable),
    .s0_read          (s0_read),
    .s0_write         (s0_write),
    .s0_writedata     (s0_writedata),
    .s0_waitrequest   (s0_waitrequest),
    .s0_readdata      (s0_readdata),
    .s0_readdatavalid (s0_readdatavalid),
    .s1_address       (s1_address),
    .s1_byteenable    (s1_byteenable),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_writedata     (s1_writedata),
    .s1_waitrequest   (s1_waitrequest),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model: byte-lane writes, registered read (one-cycle latency).
  logic [15:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_clken) begin
      if (ram_chipselect && ram_write) begin
        if (ram_byteenable[0]) mem[ram_address][7:0]  <= ram_writedata[7:0];
        if (ram_byteenable[1]) mem[ram_address][15:8] <= ram_writedata[15:8];
      end
      ram_readdata <= mem[ram_address];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
    s0_address = '0; s1_address = '0;
    s0_byteenable = 2'b11; s1_byteenable = 2'b11;
    s0_writedata = '0; s1_writedata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s0_read = 1; s1_write = 1;
    #2;
    n_tests++; if (s0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_s0_wait: got %b expected 1", s0_waitrequest); end
    n_tests++; if (s1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_s1_wait: got %b expected 1", s1_waitrequest); end
    n_tests++; if (ram_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs: got %b expected 0", ram_chipselect); end
    n_tests++; if (ram_clken !== 1'b0) begin n_fail++; $display("FAIL rst_clken: got %b expected 0", ram_clken); end
    n_tests++; if ({s0_readdatavalid, s1_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rdv: got %b expected 00", {s0_readdatavalid, s1_readdatavalid}); end
    step();
    do_reset();
    #2;
    n_tests++; if (ram_clken !== 1'b1) begin n_fail++; $display("FAIL run_clken: got %b expected 1", ram_clken); end
    step();
  endtask

  task automatic test_write_read();
    s0_write = 1; s0_address = 13'h0010; s0_byteenable = 2'b11; s0_writedata = 16'hA5A5;
    #2;
    n_tests++; if (s0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL wr_wait: got %b expected 0", s0_waitrequest); end
    n_tests++; if ({ram_chipselect, ram_write} !== 2'b11) begin n_fail++; $display("FAIL wr_ram: cs/we got %b expected 11", {ram_chipselect, ram_write}); end
    n_tests++; if (ram_writedata !== 16'hA5A5) begin n_fail++; $display("FAIL wr_data: got %h expected a5a5", ram_writedata); end
    step();
    s0_write = 0; s0_read = 1;
    #2;
    n_tests++; if (s0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rd_wait: got %b expected 0", s0_waitrequest); end
    n_tests++; if (s0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_valid: got %b expected 0", s0_readdatavalid); end
    n_tests++; if (ram_write !== 1'b0) begin n_fail++; $display("FAIL rd_we: got %b expected 0", ram_write); end
    step();
    s0_read = 0;
    #2;
    n_tests++; if (s0_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b expected 1", s0_readdatavalid); end
    n_tests++; if (s1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_other: got %b expected 0", s1_readdatavalid); end
    n_tests++; if (s0_readdata !== 16'hA5A5) begin n_fail++; $display("FAIL rd_data: got %h expected a5a5", s0_readdata); end
    step();
    #2;
    n_tests++; if (s0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_once: got %b expected 0", s0_readdatavalid); end
    step();
  endtask

  task automatic test_byte_lanes();
    s0_address = 13'h0020;
    s0_write = 1; s0_byteenable = 2'b11; s0_writedata = 16'h1234;
    step();
    s0_byteenable = 2'b10; s0_writedata = 16'hFF00;
    #2;
    n_tests++; if (ram_byteenable !== 2'b10) begin n_fail++; $display("FAIL be_pass: got %b expected 10", ram_byteenable); end
    step();
    s0_write = 0; s0_read = 1; s0_byteenable = 2'b11;
    step();
    s0_read = 0;
    #2;
    n_tests++; if ({s0_readdatavalid, s0_readdata} !== {1'b1, 16'hFF34}) begin n_fail++; $display("FAIL be_merge: got %b/%h expected 1/ff34", s0_readdatavalid, s0_readdata); end
    step();
  endtask

  task automatic test_contention();
    int exp_w;
    int prev_w;
    do_reset();
    s0_read = 1; s0_address = 13'h0010;
    s1_read = 1; s1_address = 13'h0020;
    prev_w = -1;
    for (int i = 0; i < 12; i++) begin
      exp_w = (i / 4) % 2;
      #2;
      n_tests++; if ({s1_waitrequest, s0_waitrequest} !== ((exp_w == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_grant[%0d]: wait s1s0 got %b expected port %0d", i, {s1_waitrequest, s0_waitrequest}, exp_w); end
      n_tests++; if (ram_chipselect !== 1'b1) begin n_fail++; $display("FAIL rr_bubble[%0d]: cs got %b expected 1", i, ram_chipselect); end
      if (prev_w >= 0) begin
        n_tests++; if ({s1_readdatavalid, s0_readdatavalid} !== ((prev_w == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_route[%0d]: rdv s1s0 got %b expected port %0d", i, {s1_readdatavalid, s0_readdatavalid}, prev_w); end
      end
      prev_w = exp_w;
      step();
    end
    idle_inputs();
    #2;
    n_tests++; if ({s1_readdatavalid, s0_readdatavalid} !== 2'b01) begin n_fail++; $display("FAIL rr_route_last: rdv s1s0 got %b expected 01", {s1_readdatavalid, s0_readdatavalid}); end
    n_tests++; if (s0_readdata !== 16'hA5A5) begin n_fail++; $display("FAIL rr_data: got %h expected a5a5", s0_readdata); end
    step();
  endtask

  task automatic test_saturation();
    s1_read = 1; s1_address = 13'h0020;
    for (int i = 0; i < 10; i++) begin
      #2;
      n_tests++; if (s1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL sat_solo[%0d]: s1 wait got %b expected 0", i, s1_waitrequest); end
      step();
    end
    s0_read = 1; s0_address = 13'h0010;
    #2;
    n_tests++; if ({s1_waitrequest, s0_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL sat_handover: wait s1s0 got %b expected 10", {s1_waitrequest, s0_waitrequest}); end
    n_tests++; if ({s1_readdatavalid, s1_readdata} !== {1'b1, 16'hFF34}) begin n_fail++; $display("FAIL sat_data: got %b/%h expected 1/ff34", s1_readdatavalid, s1_readdata); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    // Port 1 owns with count 1: without reset it would keep the next contested grant.
    s1_read = 1; s1_address = 13'h0020;
    step();
    s1_read = 0;
    reset_n = 1'b0;
    s0_read = 1; s1_read = 1;
    #2;
    n_tests++; if ({s1_readdatavalid, s0_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_rdv: got %b expected 00", {s1_readdatavalid, s0_readdatavalid}); end
    n_tests++; if ({s1_waitrequest, s0_waitrequest} !== 2'b11) begin n_fail++; $display("FAIL mid_rst_wait: got %b expected 11", {s1_waitrequest, s0_waitrequest}); end
    step();
    #2;
    n_tests++; if ({s1_readdatavalid, s0_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_rdv2: got %b expected 00", {s1_readdatavalid, s0_readdatavalid}); end
    step();
    reset_n = 1'b1;
    #2;
    n_tests++; if ({s1_waitrequest, s0_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL post_rst_win: wait s1s0 got %b expected 10", {s1_waitrequest, s0_waitrequest}); end
    n_tests++; if ({s1_readdatavalid, s0_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL post_rst_rdv: got %b expected 00", {s1_readdatavalid, s0_readdatavalid}); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_same_addr();
    do_reset();
    s0_write = 1; s0_address = 13'h0040; s0_writedata = 16'h1111;
    s1_write = 1; s1_address = 13'h0040; s1_writedata = 16'h2222;
    #2;
    n_tests++; if ({s1_waitrequest, s0_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL same_first: wait s1s0 got %b expected 10", {s1_waitrequest, s0_waitrequest}); end
    step();
    s0_write = 0;
    #2;
    n_tests++; if ({s1_waitrequest, s0_waitrequest} !== 2'b01) begin n_fail++; $display("FAIL same_second: wait s1s0 got %b expected 01", {s1_waitrequest, s0_waitrequest}); end
    n_tests++; if (ram_writedata !== 16'h2222) begin n_fail++; $display("FAIL same_wdata: got %h expected 2222", ram_writedata); end
    step();
    s1_write = 0;
    s0_read = 1; s0_address = 13'h0040;
    step();
    s0_read = 0;
    #2;
    n_tests++; if ({s0_readdatavalid, s0_readdata} !== {1'b1, 16'h2222}) begin n_fail++; $display("FAIL same_readback: got %b/%h expected 1/2222", s0_readdatavalid, s0_readdata); end
    step();
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 16'h0000;
    ram_readdata = 16'h0000;
    idle_inputs();
    reset_n = 1'b0;
    step();
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_contention();
    test_saturation();
    test_reset_mid_read();
    test_same_addr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
